// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the four-key debouncer.
// Counter widths bound the legal DEBOUNCE_CYCLES and LONG_CYCLES ranges.
package key_debounce_pkg;

  localparam int unsigned NUM_KEYS   = 4;
  localparam int unsigned DEB_CNT_W  = 20;
  localparam int unsigned HOLD_CNT_W = 26;

  localparam int unsigned KEY_START  = 0;
  localparam int unsigned KEY_RECORD = 1;
  localparam int unsigned KEY_PAUSE  = 2;
  localparam int unsigned KEY_LOAD   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } deb_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, press/release debounce FSM,
// and a saturating hold counter that fires a single long-press pulse.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press,
  output logic o_held,
  output logic o_long
);

  // The sample seen in the entry state counts as the first stable one,
  // so the wait states finish when the counter reaches DEBOUNCE_CYCLES-2.
  localparam logic [DEB_CNT_W-1:0]  DebLast = DEB_CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HOLD_CNT_W-1:0] HoldMax = HOLD_CNT_W'(LONG_CYCLES);
  localparam logic [HOLD_CNT_W-1:0] HoldPre = HOLD_CNT_W'(LONG_CYCLES - 1);

  logic                  r_meta;
  logic                  r_sync;
  logic                  w_synced;

  deb_state_e            r_state;
  deb_state_e            w_state_d;
  logic [DEB_CNT_W-1:0]  r_deb_cnt;
  logic [DEB_CNT_W-1:0]  w_deb_cnt_d;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [HOLD_CNT_W-1:0] w_hold_cnt_d;
  logic                  r_press;
  logic                  w_press_d;
  logic                  r_long;
  logic                  w_long_d;

  assign w_synced = ~r_sync;

  always_comb begin
    w_state_d    = r_state;
    w_deb_cnt_d  = r_deb_cnt;
    w_hold_cnt_d = r_hold_cnt;
    w_press_d    = 1'b0;
    w_long_d     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_deb_cnt_d  = '0;
        w_hold_cnt_d = '0;
        if (w_synced) begin
          w_state_d = StPressWait;
        end
      end

      StPressWait: begin
        if (!w_synced) begin
          w_state_d   = StIdle;
          w_deb_cnt_d = '0;
        end else if (r_deb_cnt == DebLast) begin
          w_state_d    = StPressed;
          w_deb_cnt_d  = '0;
          w_hold_cnt_d = '0;
          w_press_d    = 1'b1;
        end else begin
          w_deb_cnt_d = r_deb_cnt + DEB_CNT_W'(1);
        end
      end

      StPressed: begin
        if (r_hold_cnt != HoldMax) begin
          w_hold_cnt_d = r_hold_cnt + HOLD_CNT_W'(1);
          w_long_d     = (r_hold_cnt == HoldPre);
        end
        if (!w_synced) begin
          w_state_d   = StReleaseWait;
          w_deb_cnt_d = '0;
        end
      end

      StReleaseWait: begin
        // A bounce back to pressed resumes the hold without a new press pulse.
        if (w_synced) begin
          w_state_d = StPressed;
        end else if (r_deb_cnt == DebLast) begin
          w_state_d   = StIdle;
          w_deb_cnt_d = '0;
        end else begin
          w_deb_cnt_d = r_deb_cnt + DEB_CNT_W'(1);
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta     <= 1'b1;
      r_sync     <= 1'b1;
      r_state    <= StIdle;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_meta     <= i_key_n;
      r_sync     <= r_meta;
      r_state    <= w_state_d;
      r_deb_cnt  <= w_deb_cnt_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_press    <= w_press_d;
      r_long     <= w_long_d;
    end
  end

  assign o_press = r_press;
  assign o_long  = r_long;
  assign o_held  = (r_state == StPressed) || (r_state == StReleaseWait);

endmodule

// File: rtl/key_debounce.sv
// Four independent debounced push-buttons with press, held and long-press
// outputs; the top only maps channel bits onto the named pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in_n,
  output logic       key_start,
  output logic       key_Record,
  output logic       key_pause,
  output logic       key_load,
  output logic [3:0] key_held,
  output logic [3:0] key_long
);

  logic [NUM_KEYS-1:0] w_press;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_key_n (key_in_n[g]),
      .o_press (w_press[g]),
      .o_held  (key_held[g]),
      .o_long  (key_long[g])
    );
  end

  assign key_start  = w_press[KEY_START];
  assign key_Record = w_press[KEY_RECORD];
  assign key_pause  = w_press[KEY_PAUSE];
  assign key_load   = w_press[KEY_LOAD];

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench: a run-length reference model predicts every output cycle,
// a monitor compares, and directed scenarios queue event-timing expectations.
module tb_key_debounce;

  localparam int D = 8;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in_n;
  logic       key_start, key_Record, key_pause, key_load;
  logic [3:0] key_held, key_long;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in_n   (key_in_n),
    .key_start  (key_start),
    .key_Record (key_Record),
    .key_pause  (key_pause),
    .key_load   (key_load),
    .key_held   (key_held),
    .key_long   (key_long)
  );

  typedef struct packed {
    logic [3:0] press;
    logic [3:0] held;
    logic [3:0] lng;
  } exp_t;

  typedef struct packed {
    int id;
    int expv;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dir_q[$];

  int checks;
  int errors;
  int cyc;

  // Event log kept by the monitor, read by the directed scenarios.
  int n_start, t_start, n_long0, t_long0, n_pause, t_pause;
  int n_record, held1_cyc, n_load, t_load, t_held0_fall;

  // Reference model: a key is accepted after D consecutive equal synchronized
  // samples; hold time counts cycles spent pressed without a pending release.
  initial begin : model
    bit s1[4], s2[4], s2p[4], st[4];
    int ones[4], zeros[4], hold[4];
    bit sy, syp;
    exp_t e;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      s1[k] = 0; s2[k] = 0; s2p[k] = 0; st[k] = 0;
      ones[k] = 0; zeros[k] = 0; hold[k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      for (int k = 0; k < 4; k++) begin
        if (!rst_n) begin
          s1[k] = 0; s2[k] = 0; s2p[k] = 0; st[k] = 0;
          ones[k] = 0; zeros[k] = 0; hold[k] = 0;
        end else begin
          sy  = s2[k];
          syp = s2p[k];
          if (sy) begin ones[k]++; zeros[k] = 0; end
          else begin zeros[k]++; ones[k] = 0; end
          if (st[k] && syp && hold[k] < L) begin
            hold[k]++;
            if (hold[k] == L) e.lng[k] = 1'b1;
          end
          if (!st[k] && ones[k] >= D) begin
            st[k] = 1; e.press[k] = 1'b1; hold[k] = 0;
          end else if (st[k] && zeros[k] >= D) begin
            st[k] = 0;
          end
          e.held[k] = st[k];
          s2p[k] = s2[k];
          s2[k]  = s1[k];
          s1[k]  = !key_in_n[k];
        end
      end
      exp_q.push_back(e);
    end
  end

  function automatic string dname(input int id);
    case (id)
      0: return "start_count";
      1: return "start_cycle";
      2: return "long0_cycle";
      3: return "long0_count";
      4: return "pause_count";
      5: return "pause_cycle";
      6: return "record_count";
      7: return "held1_cycles";
      8: return "load_cycle";
      9: return "held0_fall_cycle";
      default: return "load_count";
    endcase
  endfunction

  function automatic int dactual(input int id);
    case (id)
      0: return n_start;
      1: return t_start;
      2: return t_long0;
      3: return n_long0;
      4: return n_pause;
      5: return t_pause;
      6: return n_record;
      7: return held1_cyc;
      8: return t_load;
      9: return t_held0_fall;
      default: return n_load;
    endcase
  endfunction

  initial begin : monitor
    exp_t       e;
    dchk_t      d;
    logic [3:0] press;
    logic       prev_held0;
    checks = 0; errors = 0;
    n_start = 0; t_start = -1; n_long0 = 0; t_long0 = -1; n_pause = 0; t_pause = -1;
    n_record = 0; held1_cyc = 0; n_load = 0; t_load = -1; t_held0_fall = -1;
    prev_held0 = 1'b0;
    forever begin
      @(negedge clk);
      press = {key_load, key_pause, key_Record, key_start};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty cycle %0d: got no expectation, required one", cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (press !== e.press) begin
          errors++;
          $display("FAIL press cycle %0d: got %b required %b", cyc, press, e.press);
        end
        checks++;
        if (key_held !== e.held) begin
          errors++;
          $display("FAIL held cycle %0d: got %b required %b", cyc, key_held, e.held);
        end
        checks++;
        if (key_long !== e.lng) begin
          errors++;
          $display("FAIL long cycle %0d: got %b required %b", cyc, key_long, e.lng);
        end
      end
      if (key_start === 1'b1) begin n_start++; t_start = cyc; end
      if (key_long[0] === 1'b1) begin n_long0++; t_long0 = cyc; end
      if (key_pause === 1'b1) begin n_pause++; t_pause = cyc; end
      if (key_Record === 1'b1) n_record++;
      if (key_held[1] === 1'b1) held1_cyc++;
      if (key_load === 1'b1) begin n_load++; t_load = cyc; end
      if (prev_held0 && key_held[0] === 1'b0) t_held0_fall = cyc;
      prev_held0 = (key_held[0] === 1'b1);
      while (dir_q.size() > 0) begin
        d = dir_q.pop_front();
        checks++;
        if (dactual(d.id) != d.expv) begin
          errors++;
          $display("FAIL %s: got %0d required %0d", dname(d.id), dactual(d.id), d.expv);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic expect_dir(input int id, input int v);
    dchk_t d;
    d.id = id;
    d.expv = v;
    dir_q.push_back(d);
  endtask

  initial begin : driver
    int t0, tr, b0, b1, b2;
    int seg[4];
    int rst_left;
    logic [3:0] lvl;
    rst_n = 1'b0;
    key_in_n = 4'hF;
    steps(3);
    rst_n = 1'b1;
    steps(3);

    // Clean press of start held 40 cycles.
    b0 = n_start; b1 = n_long0;
    key_in_n = 4'b1110; t0 = cyc;
    steps(40);
    key_in_n = 4'hF;
    steps(15);
    expect_dir(0, b0 + 1); expect_dir(1, t0 + 10);
    expect_dir(3, b1 + 1); expect_dir(2, t0 + 30);

    // Pause bounces 1,0,1,0 (3 cycles each) then holds.
    b0 = n_pause;
    key_in_n[2] = 1'b0; steps(3);
    key_in_n[2] = 1'b1; steps(3);
    key_in_n[2] = 1'b0; steps(3);
    key_in_n[2] = 1'b1; steps(3);
    key_in_n[2] = 1'b0; t0 = cyc;
    steps(20);
    key_in_n[2] = 1'b1;
    steps(15);
    expect_dir(4, b0 + 1); expect_dir(5, t0 + 10);

    // Short record press is rejected.
    b0 = n_record; b1 = held1_cyc;
    key_in_n[1] = 1'b0; steps(5);
    key_in_n[1] = 1'b1; steps(15);
    expect_dir(6, b0); expect_dir(7, b1);

    // Simultaneous start and load.
    b0 = n_start; b1 = n_load;
    key_in_n = 4'b0110; t0 = cyc;
    steps(12);
    key_in_n = 4'hF;
    steps(15);
    expect_dir(0, b0 + 1); expect_dir(10, b1 + 1);
    expect_dir(1, t0 + 10); expect_dir(8, t0 + 10);

    // Release with a 3-cycle glitch back to pressed.
    b0 = n_start;
    key_in_n[0] = 1'b0; steps(12);
    key_in_n[0] = 1'b1; steps(2);
    key_in_n[0] = 1'b0; steps(3);
    key_in_n[0] = 1'b1; tr = cyc;
    steps(15);
    expect_dir(0, b0 + 1); expect_dir(9, tr + 10);

    // Reset while pressed, key kept down through and after reset.
    key_in_n[0] = 1'b0; steps(15);
    rst_n = 1'b0; t0 = cyc;
    steps(2);
    expect_dir(9, t0 + 1);
    rst_n = 1'b1; tr = cyc; b2 = n_start;
    steps(15);
    key_in_n[0] = 1'b1;
    steps(15);
    expect_dir(0, b2 + 1); expect_dir(1, tr + 10);

    // Randomized bouncing on all keys with occasional resets.
    lvl = 4'hF;
    for (int k = 0; k < 4; k++) seg[k] = $urandom_range(1, 20);
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (seg[k] == 0) begin
          lvl[k] = ~lvl[k];
          seg[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end
        seg[k]--;
      end
      key_in_n = lvl;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 3);
      rst_n = (rst_left == 0);
    end
    rst_n = 1'b1;
    key_in_n = 4'hF;
    steps(30);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
